// File: rtl/id_stage.sv
// Registered RV32I decode stage: instruction decode, register-file read, EX/MEM
// forwarding, load-use hazard bubbles and a valid/ready ID/EX pipeline register.
module id_stage #(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int FWD_MM      = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_inst,
  output logic                   rf_re1,
  output logic                   rf_re2,
  output logic [RA_W-1:0]        rf_ra1,
  output logic [RA_W-1:0]        rf_ra2,
  input  logic [XLEN-1:0]        rf_rd1,
  input  logic [XLEN-1:0]        rf_rd2,
  input  logic                   ex_we,
  input  logic [RA_W-1:0]        ex_wa,
  input  logic [XLEN-1:0]        ex_wd,
  input  logic                   ex_is_load,
  input  logic                   mm_we,
  input  logic [RA_W-1:0]        mm_wa,
  input  logic [XLEN-1:0]        mm_wd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic                   out_funct7b5,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [XLEN-1:0]        out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic [RA_W-1:0]        out_wa,
  output logic                   out_we,
  output logic                   out_mem_rd,
  output logic                   out_mem_wr,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [RA_W-1:0] rs1_a, rs2_a, rd_a;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            use1, use2, wr_op, mem_rd, mem_wr, illegal;
  logic [XLEN-1:0] rs1_val, rs2_val, op1, op2;
  logic            hazard, adv;

  logic                   valid_q, we_q, mem_rd_q, mem_wr_q, illegal_q, f7b5_q;
  logic [XLEN-1:0]        pc_q, op1_q, op2_q, rs2_q, imm_q;
  logic [6:0]             opc_q;
  logic [2:0]             f3_q;
  logic [RA_W-1:0]        wa_q;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign rs1_a = RA_W'(in_inst[19:15]);
  assign rs2_a = RA_W'(in_inst[24:20]);
  assign rd_a  = RA_W'(in_inst[11:7]);

  // Immediate is formed in 32 bits, then sign-extended to the datapath width.
  always_comb begin
    imm32 = 32'd0;
    case (opc)
      OPC_OPIMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) imm32 = {27'd0, in_inst[24:20]};
        else                              imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_JALR, OPC_LOAD: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      OPC_STORE:  imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      OPC_BRANCH: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {in_inst[31:12], 12'd0};
      OPC_JAL:    imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
      default:    imm32 = 32'd0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    wr_op   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: wr_op = 1'b1;
      OPC_JALR:   begin use1 = 1'b1; wr_op = 1'b1; end
      OPC_BRANCH: begin use1 = 1'b1; use2 = 1'b1; end
      OPC_LOAD:   begin use1 = 1'b1; wr_op = 1'b1; mem_rd = 1'b1; end
      OPC_STORE:  begin use1 = 1'b1; use2 = 1'b1; mem_wr = 1'b1; end
      OPC_OPIMM:  begin use1 = 1'b1; wr_op = 1'b1; end
      OPC_OP:     begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; end
      OPC_MISC, OPC_SYSTEM: ;
      default:    illegal = 1'b1;
    endcase
  end

  function automatic logic [XLEN-1:0] resolve(
    input logic            used,
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] rf_val,
    input logic            e_we,
    input logic [RA_W-1:0] e_wa,
    input logic [XLEN-1:0] e_wd,
    input logic            m_we,
    input logic [RA_W-1:0] m_wa,
    input logic [XLEN-1:0] m_wd
  );
    if (!used || addr == '0)                         return '0;
    else if (e_we && e_wa == addr)                   return e_wd;
    else if (FWD_MM != 0 && m_we && m_wa == addr)    return m_wd;
    else                                             return rf_val;
  endfunction

  assign rs1_val = resolve(use1, rs1_a, rf_rd1, ex_we, ex_wa, ex_wd, mm_we, mm_wa, mm_wd);
  assign rs2_val = resolve(use2, rs2_a, rf_rd2, ex_we, ex_wa, ex_wd, mm_we, mm_wa, mm_wd);

  always_comb begin
    op1 = rs1_val;
    op2 = '0;
    case (opc)
      OPC_LUI:                       begin op1 = '0;    op2 = imm; end
      OPC_AUIPC:                     begin op1 = in_pc; op2 = imm; end
      OPC_JAL, OPC_JALR:             begin op1 = in_pc; op2 = XLEN'(4); end
      OPC_LOAD, OPC_STORE, OPC_OPIMM: op2 = imm;
      OPC_OP, OPC_BRANCH:            op2 = rs2_val;
      default:                       op2 = '0;
    endcase
  end

  // A load in EX cannot forward yet, so any used source matching it must wait.
  assign hazard = in_valid && ex_is_load && ex_we && (ex_wa != '0) &&
                  ((use1 && ex_wa == rs1_a) || (use2 && ex_wa == rs2_a));
  assign adv      = !valid_q || out_ready;
  assign in_ready = rst_n && (flush || (adv && !hazard));

  assign rf_re1 = use1;
  assign rf_re2 = use2;
  assign rf_ra1 = rs1_a;
  assign rf_ra2 = rs2_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opc_q     <= '0;
      f3_q      <= '0;
      f7b5_q    <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      wa_q      <= '0;
      we_q      <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      if (in_valid && !hazard) begin
        valid_q   <= (in_inst != 32'd0);
        pc_q      <= in_pc;
        opc_q     <= opc;
        f3_q      <= f3;
        f7b5_q    <= in_inst[30];
        op1_q     <= op1;
        op2_q     <= op2;
        rs2_q     <= rs2_val;
        imm_q     <= imm;
        wa_q      <= rd_a;
        we_q      <= wr_op && (rd_a != '0);
        mem_rd_q  <= mem_rd;
        mem_wr_q  <= mem_wr;
        illegal_q <= illegal;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard && adv && !flush && stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_opcode   = opc_q;
  assign out_funct3   = f3_q;
  assign out_funct7b5 = f7b5_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_rs2      = rs2_q;
  assign out_imm      = imm_q;
  assign out_wa       = wa_q;
  assign out_we       = we_q;
  assign out_mem_rd   = mem_rd_q;
  assign out_mem_wr   = mem_wr_q;
  assign out_illegal  = illegal_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// hazard, backpressure, flush and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, outReady, flush;
  logic [31:0] inPc, inInst, rd1, rd2, exWd, mmWd;
  logic        exWe, exIsLoad, mmWe;
  logic [4:0]  exWa, mmWa;

  logic        inReady, re1, re2, outValid, outWe, outMemRd, outMemWr, outIll, outF7b5;
  logic [4:0]  ra1, ra2, outWa;
  logic [31:0] outPc, outOp1, outOp2, outRs2, outImm;
  logic [6:0]  outOpc;
  logic [2:0]  outF3;
  logic [15:0] stallCnt;

  logic        bInReady, bRe1, bRe2, bOutValid, bOutWe, bOutMemRd, bOutMemWr, bOutIll, bOutF7b5;
  logic [4:0]  bRa1, bRa2, bOutWa;
  logic [31:0] bOutPc, bOutOp1, bOutOp2, bOutRs2, bOutImm;
  logic [6:0]  bOutOpc;
  logic [2:0]  bOutF3;
  logic [1:0]  bStallCnt;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady), .in_pc(inPc),
    .in_inst(inInst), .rf_re1(re1), .rf_re2(re2), .rf_ra1(ra1), .rf_ra2(ra2),
    .rf_rd1(rd1), .rf_rd2(rd2), .ex_we(exWe), .ex_wa(exWa), .ex_wd(exWd),
    .ex_is_load(exIsLoad), .mm_we(mmWe), .mm_wa(mmWa), .mm_wd(mmWd), .flush(flush),
    .out_valid(outValid), .out_ready(outReady), .out_pc(outPc), .out_opcode(outOpc),
    .out_funct3(outF3), .out_funct7b5(outF7b5), .out_op1(outOp1), .out_op2(outOp2),
    .out_rs2(outRs2), .out_imm(outImm), .out_wa(outWa), .out_we(outWe),
    .out_mem_rd(outMemRd), .out_mem_wr(outMemWr), .out_illegal(outIll),
    .stall_cnt(stallCnt)
  );

  // Second instance: no MEM forwarding and a 2-bit counter that saturates quickly.
  id_stage #(.FWD_MM(0), .STALL_CNT_W(2)) dutNoMm (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(bInReady), .in_pc(inPc),
    .in_inst(inInst), .rf_re1(bRe1), .rf_re2(bRe2), .rf_ra1(bRa1), .rf_ra2(bRa2),
    .rf_rd1(rd1), .rf_rd2(rd2), .ex_we(exWe), .ex_wa(exWa), .ex_wd(exWd),
    .ex_is_load(exIsLoad), .mm_we(mmWe), .mm_wa(mmWa), .mm_wd(mmWd), .flush(flush),
    .out_valid(bOutValid), .out_ready(outReady), .out_pc(bOutPc), .out_opcode(bOutOpc),
    .out_funct3(bOutF3), .out_funct7b5(bOutF7b5), .out_op1(bOutOp1), .out_op2(bOutOp2),
    .out_rs2(bOutRs2), .out_imm(bOutImm), .out_wa(bOutWa), .out_we(bOutWe),
    .out_mem_rd(bOutMemRd), .out_mem_wr(bOutMemWr), .out_illegal(bOutIll),
    .stall_cnt(bStallCnt)
  );

  typedef struct {
    logic [31:0] inst, pc, rd1, rd2;
    logic        exWe;
    logic [4:0]  exWa;
    logic [31:0] exWd;
    logic        mmWe;
    logic [4:0]  mmWa;
    logic [31:0] mmWd;
    logic        eValid, eRe1, eRe2;
    logic [31:0] eOp1, eOp2, eOp2NoMm, eRs2, eImm;
    logic [4:0]  eWa;
    logic        eWe, eMemRd, eMemWr, eIll;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    inValid  = 1'b1;
    inInst   = v.inst;
    inPc     = v.pc;
    rd1      = v.rd1;
    rd2      = v.rd2;
    exWe     = v.exWe;
    exWa     = v.exWa;
    exWd     = v.exWd;
    exIsLoad = 1'b0;
    mmWe     = v.mmWe;
    mmWa     = v.mmWa;
    mmWd     = v.mmWd;
  endtask

  initial begin
    logic [31:0] w;
    // inst, pc, rd1, rd2, exWe, exWa, exWd, mmWe, mmWa, mmWd,
    // eValid, eRe1, eRe2, eOp1, eOp2, eOp2NoMm, eRs2, eImm, eWa, eWe, eMemRd, eMemWr, eIll
    vecs[0]  = '{32'h00500093, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 0, 5, 5, 0, 5, 1, 1, 0, 0, 0};
    vecs[1]  = '{32'h002081B3, 32'h104, 32'hFF, 32'hFF, 1, 1, 32'h11, 1, 2, 32'h22,
                 1, 1, 1, 32'h11, 32'h22, 32'hFF, 32'h22, 0, 3, 1, 0, 0, 0};
    vecs[2]  = '{32'h002081B3, 32'h108, 32'hFF, 32'hFF, 1, 1, 32'h11, 1, 1, 32'h33,
                 1, 1, 1, 32'h11, 32'hFF, 32'hFF, 32'hFF, 0, 3, 1, 0, 0, 0};
    vecs[3]  = '{32'hFE000EE3, 32'h10C, 5, 6, 0, 0, 0, 0, 0, 0,
                 1, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 29, 0, 0, 0, 0};
    vecs[4]  = '{32'h001000EF, 32'h200, 5, 6, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 32'h200, 4, 4, 0, 32'h800, 1, 1, 0, 0, 0};
    vecs[5]  = '{32'h01F31293, 32'h204, 32'h1234, 6, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 32'h1234, 31, 31, 0, 31, 5, 1, 0, 0, 0};
    vecs[6]  = '{32'h40335293, 32'h208, 32'h80000000, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 32'h80000000, 3, 3, 0, 3, 5, 1, 0, 0, 0};
    vecs[7]  = '{32'h000000FF, 32'h20C, 5, 6, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[8]  = '{32'hFF812383, 32'h210, 32'h1000, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 32'h1000, 32'hFFFFFFF8, 32'hFFFFFFF8, 0, 32'hFFFFFFF8, 7, 1, 1, 0, 0};
    vecs[9]  = '{32'h00322623, 32'h214, 32'h2000, 32'hABCD, 0, 0, 0, 1, 3, 32'h5555,
                 1, 1, 1, 32'h2000, 12, 12, 32'h5555, 12, 12, 0, 0, 1, 0};
    vecs[10] = '{32'h12345437, 32'h218, 5, 6, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 32'h12345000, 32'h12345000, 0, 32'h12345000, 8, 1, 0, 0, 0};
    vecs[11] = '{32'hFFFFF497, 32'h300, 5, 6, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 32'h300, 32'hFFFFF000, 32'hFFFFF000, 0, 32'hFFFFF000, 9, 1, 0, 0, 0};
    vecs[12] = '{32'h010280E7, 32'h40, 32'h400, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 32'h40, 4, 4, 0, 16, 1, 1, 0, 0, 0};
    vecs[13] = '{32'h00000013, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{32'h00000000, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{32'h000010F3, 32'h4C, 5, 6, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    rstN = 1'b1; inValid = 1'b0; outReady = 1'b1; flush = 1'b0;
    inPc = '0; inInst = '0; rd1 = '0; rd2 = '0;
    exWe = 1'b0; exWa = '0; exWd = '0; exIsLoad = 1'b0;
    mmWe = 1'b0; mmWa = '0; mmWd = '0;
    #1 rstN = 1'b0;
    #3;
    checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, inReady}, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stallCnt}, 32'd0);
    checkOutput("rst_out_op2", outOp2, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      w = vecs[i].inst;
      #1;
      checkOutput($sformatf("v%0d_in_ready", i), {31'd0, inReady}, 32'd1);
      checkOutput($sformatf("v%0d_rf_re1", i), {31'd0, re1}, {31'd0, vecs[i].eRe1});
      checkOutput($sformatf("v%0d_rf_re2", i), {31'd0, re2}, {31'd0, vecs[i].eRe2});
      checkOutput($sformatf("v%0d_rf_ra1", i), {27'd0, ra1}, {27'd0, w[19:15]});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_out_valid", i), {31'd0, outValid}, {31'd0, vecs[i].eValid});
      if (vecs[i].eValid) begin
        checkOutput($sformatf("v%0d_pc", i), outPc, vecs[i].pc);
        checkOutput($sformatf("v%0d_opcode", i), {25'd0, outOpc}, {25'd0, w[6:0]});
        checkOutput($sformatf("v%0d_funct3", i), {29'd0, outF3}, {29'd0, w[14:12]});
        checkOutput($sformatf("v%0d_funct7b5", i), {31'd0, outF7b5}, {31'd0, w[30]});
        checkOutput($sformatf("v%0d_op1", i), outOp1, vecs[i].eOp1);
        checkOutput($sformatf("v%0d_op2", i), outOp2, vecs[i].eOp2);
        checkOutput($sformatf("v%0d_op2_nomm", i), bOutOp2, vecs[i].eOp2NoMm);
        checkOutput($sformatf("v%0d_rs2", i), outRs2, vecs[i].eRs2);
        checkOutput($sformatf("v%0d_imm", i), outImm, vecs[i].eImm);
        checkOutput($sformatf("v%0d_wa", i), {27'd0, outWa}, {27'd0, vecs[i].eWa});
        checkOutput($sformatf("v%0d_we", i), {31'd0, outWe}, {31'd0, vecs[i].eWe});
        checkOutput($sformatf("v%0d_mem_rd", i), {31'd0, outMemRd}, {31'd0, vecs[i].eMemRd});
        checkOutput($sformatf("v%0d_mem_wr", i), {31'd0, outMemWr}, {31'd0, vecs[i].eMemWr});
        checkOutput($sformatf("v%0d_illegal", i), {31'd0, outIll}, {31'd0, vecs[i].eIll});
      end
    end

    // Load-use on rs1: one bubble, then the same instruction goes through with EX data.
    @(negedge clk);
    inValid = 1'b1; inInst = 32'h002081B3; inPc = 32'h400; rd1 = '0; rd2 = '0;
    mmWe = 1'b0; exIsLoad = 1'b1; exWe = 1'b1; exWa = 5'd1; exWd = '0;
    #1 checkOutput("lu_in_ready", {31'd0, inReady}, 32'd0);
    @(posedge clk); #1;
    checkOutput("lu_bubble_valid", {31'd0, outValid}, 32'd0);
    checkOutput("lu_stall_cnt", {16'd0, stallCnt}, 32'd1);
    checkOutput("lu_stall_cnt_small", {30'd0, bStallCnt}, 32'd1);
    @(negedge clk);
    exIsLoad = 1'b0; exWd = 32'h77;
    #1 checkOutput("lu_accept_ready", {31'd0, inReady}, 32'd1);
    @(posedge clk); #1;
    checkOutput("lu_accept_valid", {31'd0, outValid}, 32'd1);
    checkOutput("lu_accept_op1", outOp1, 32'h77);
    checkOutput("lu_accept_stall", {16'd0, stallCnt}, 32'd1);

    // A load targeting a register the instruction does not read is no hazard.
    @(negedge clk);
    inInst = 32'h00500093; exIsLoad = 1'b1; exWe = 1'b1; exWa = 5'd5;
    #1 checkOutput("lu_unused_ready", {31'd0, inReady}, 32'd1);
    @(posedge clk); #1;
    checkOutput("lu_unused_valid", {31'd0, outValid}, 32'd1);
    checkOutput("lu_unused_stall", {16'd0, stallCnt}, 32'd1);

    // Four more hazard cycles on rs2: wide counter reaches 5, 2-bit one saturates at 3.
    @(negedge clk);
    inInst = 32'h002081B3; exIsLoad = 1'b1; exWe = 1'b1; exWa = 5'd2;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("sat_stall_cnt", {16'd0, stallCnt}, 32'd5);
    checkOutput("sat_stall_cnt_small", {30'd0, bStallCnt}, 32'd3);

    // Backpressure: output held for three cycles, then the waiting LUI is taken.
    @(negedge clk);
    exIsLoad = 1'b0; exWe = 1'b0; rd1 = 32'hA; rd2 = 32'hB;
    @(posedge clk); #1;
    checkOutput("bp_fill_op1", outOp1, 32'hA);
    @(negedge clk);
    outReady = 1'b0; inInst = 32'h12345437; inPc = 32'h500;
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput($sformatf("bp%0d_in_ready", c), {31'd0, inReady}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_valid", c), {31'd0, outValid}, 32'd1);
      checkOutput($sformatf("bp%0d_op1", c), outOp1, 32'hA);
      checkOutput($sformatf("bp%0d_op2", c), outOp2, 32'hB);
      checkOutput($sformatf("bp%0d_wa", c), {27'd0, outWa}, 32'd3);
      @(negedge clk);
    end
    outReady = 1'b1;
    #1 checkOutput("bp_release_ready", {31'd0, inReady}, 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_release_op2", outOp2, 32'h12345000);
    checkOutput("bp_release_wa", {27'd0, outWa}, 32'd8);
    checkOutput("bp_release_pc", outPc, 32'h500);

    // Flush together with a hazard: input consumed, register emptied, no stall counted.
    @(negedge clk);
    flush = 1'b1; inInst = 32'h002081B3; exIsLoad = 1'b1; exWe = 1'b1; exWa = 5'd1;
    #1 checkOutput("fl_in_ready", {31'd0, inReady}, 32'd1);
    @(posedge clk); #1;
    checkOutput("fl_valid", {31'd0, outValid}, 32'd0);
    checkOutput("fl_stall_cnt", {16'd0, stallCnt}, 32'd5);

    // Asynchronous reset in the middle of a stall.
    @(negedge clk);
    flush = 1'b0; exIsLoad = 1'b0; exWe = 1'b0; inInst = 32'h00500093; inPc = 32'h600;
    @(posedge clk); #1;
    checkOutput("ar_pre_valid", {31'd0, outValid}, 32'd1);
    @(negedge clk);
    inInst = 32'h002081B3; exIsLoad = 1'b1; exWe = 1'b1; exWa = 5'd1;
    #1 checkOutput("ar_stall_ready", {31'd0, inReady}, 32'd0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("ar_valid", {31'd0, outValid}, 32'd0);
    checkOutput("ar_stall_cnt", {16'd0, stallCnt}, 32'd0);
    checkOutput("ar_stall_cnt_small", {30'd0, bStallCnt}, 32'd0);
    checkOutput("ar_op2", outOp2, 32'd0);
    checkOutput("ar_wa", {27'd0, outWa}, 32'd0);
    checkOutput("ar_we", {31'd0, outWe}, 32'd0);
    checkOutput("ar_pc", outPc, 32'd0);
    checkOutput("ar_in_ready", {31'd0, inReady}, 32'd0);
    inValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered RV32I decode stage: decodes one instruction per cycle from IF and reads the register file.
- Resolves operands with EX/MEM forwarding and detects load-use hazards, inserting one bubble per hazard.
- Presents a valid/ready ID/EX pipeline register to EX.
- Successor to the combinational decoder: full RV32I immediate/format coverage, parametrised width, backpressure, flush, stall counter.

Parameters:
XLEN, 32, datapath/operand width (opcodes stay RV32I)
RA_W, 5, register address width
FWD_MM, 1, 1 enables MEM-stage forwarding; 0 means MEM results come only via RF
STALL_CNT_W, 16, width of saturating hazard-stall counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF presents instruction
in_ready  out  1  ID accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_inst  in  32  instruction word
rf_re1/rf_re2  out  1  RF read enables
rf_ra1/rf_ra2  out  RA_W  RF read addresses
rf_rd1/rf_rd2  in  XLEN  RF read data (combinational)
ex_we, ex_wa, ex_wd  in  1/RA_W/XLEN  EX-stage pending write
ex_is_load  in  1  EX instruction is a load (data not yet available)
mm_we, mm_wa, mm_wd  in  1/RA_W/XLEN  MEM-stage pending write
flush  in  1  kill ID/EX contents and discard incoming instruction
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts
out_pc  out  XLEN  PC
out_opcode, out_funct3, out_funct7b5  out  7/3/1  decode fields (inst[6:0], [14:12], [30])
out_op1, out_op2  out  XLEN  ALU operands
out_rs2  out  XLEN  store/branch data (forwarded rs2)
out_imm  out  XLEN  sign-extended immediate
out_wa, out_we  out  RA_W/1  destination register
out_mem_rd, out_mem_wr  out  1  load/store flags
out_illegal  out  1  unsupported opcode
stall_cnt  out  STALL_CNT_W  hazard stall cycles, saturating

Behaviour:
- Reset (rst_n low, async): all out_* = 0, stall_cnt = 0. in_ready = 0 while in reset.
- Immediates:
  - I: sign-extended inst[31:20].
  - Shift-immediate (funct3 001/101): zero-extended inst[24:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to XLEN.
- Read enables:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rf_ra* = inst fields always; rf_re* = use flags.
- Operand resolution, per source, priority order:
  - address 0 or not used → 0
  - ex_we && ex_wa == addr → ex_wd
  - FWD_MM && mm_we && mm_wa == addr → mm_wd
  - otherwise rf_rd.
- op1 / op2 selection:
  - op1 = rs1 value; LUI → 0; AUIPC/JAL → pc; JALR → pc.
  - op2 = imm for LUI/AUIPC/LOAD/STORE/OP-IMM; 4 for JAL/JALR; rs2 for OP/BRANCH.
- Write enable and illegal:
  - out_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd ≠ 0.
  - MISC-MEM/SYSTEM decode as nop (we = 0).
  - Any other opcode: out_illegal = 1, we = 0, mem flags = 0.
- Load-use hazard: hazard = in_valid && ex_is_load && ex_we && ex_wa ≠ 0 && ex_wa equals a used source address.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv && !hazard, or 1 whenever flush = 1 (input consumed and discarded).
- ID/EX register, per posedge:
  - flush → out_valid <= 0.
  - Else if adv: when in_valid && !hazard, capture decode and set out_valid <= (in_inst ≠ 0), so an all-zero word is a bubble; otherwise out_valid <= 0 (hazard bubble).
  - Else hold all outputs stable (out_ready = 0 backpressure).
- stall_cnt: +1 on each cycle with hazard && adv && !flush; saturates at all-ones.
- Latency: 1 cycle from accept to out_valid. Forwarded values are sampled at accept time.
- Simultaneous flush and hazard: flush wins, no stall counted.
- Async reset mid-transaction clears out_valid immediately.

Test Plan:
- ADDI x1,x0,5 (0x00500093), RF zeros, out_ready = 1 → next cycle out_valid = 1, out_op1 = 0, out_op2 = 5, out_wa = 1, out_we = 1.
- ADD x3,x1,x2 with ex_we = 1, ex_wa = 1, ex_wd = 0x11; mm_we = 1, mm_wa = 2, mm_wd = 0x22; rf_rd* = 0xFF → out_op1 = 0x11, out_op2 = 0x22. Repeat with FWD_MM = 0 → out_op2 = 0xFF.
- Load-use: ex_is_load = 1, ex_wa = 1, instruction uses x1 → in_ready = 0 one cycle, out_valid = 0 bubble, stall_cnt = 1. Next cycle (ex_is_load = 0) the instruction is accepted.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with new in_valid → in_ready = 0, outputs unchanged. out_ready = 1 → new instruction latched.
- Immediates: BEQ with offset -4 → out_imm = 0xFFFFFFFC. JAL x1,+2048 → out_op1 = pc, out_op2 = 4, out_imm = 0x800. SLLI shamt 31 → out_imm = 31.
- flush with out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle, in_ready = 1. Opcode 0x7F → out_illegal = 1, out_we = 0. Assert rst_n = 0 mid-stall → all outputs and stall_cnt = 0 immediately.
